tub_encoder: RTL and testbench
==============================

TUB_ENCODER -- requirements
Module: tub_encoder

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: wr_en  input  1  single-cycle register-write strobe from the CPU MMIO decoder.
REQ-004 SHALL have port: addr  input  2  register select: 0 = VALUE, 1 = MODE, 2 = MASK, 3 = reserved.
REQ-005 SHALL have port: wdata  input  32  write data.
REQ-006 SHALL have port: busy  output  1  high while a render is pending or in progress.
REQ-007 SHALL have ports: tub1..tub8  output  8 each  segment codes for the digit scanner; tub1 is the leftmost, most significant digit.

Function
REQ-008 SHALL encode segment bits as {a,b,c,d,e,f,g,dp}, MSB = a, 1 = lit; dp is always 0.
REQ-009 SHALL use these digit codes: 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0, 8=FE, 9=F6, A=EE, b=3E, C=9C, d=7A, E=9E, F=8E; dash = 02; blank = 00.
REQ-010 SHALL store registers: VALUE = wdata[31:0]; MODE = wdata[1:0] (bit0: 0 hex, 1 unsigned decimal; bit1: leading-zero suppression); MASK = wdata[7:0] (bit7 -> tub1 ... bit0 -> tub8).
REQ-011 Each write to addr 0..2 SHALL update the register at that edge and trigger a render; a write to addr 3 SHALL be ignored.
REQ-012 SHALL implement an FSM with states IDLE, CONV, RENDER; busy = (state != IDLE).
REQ-013 Hex render: write at edge N -> RENDER; at edge N+1 the outputs update and the FSM returns to IDLE.
REQ-014 Hex render SHALL map tub1..tub8 to VALUE nibbles [31:28] .. [3:0].
REQ-015 Decimal render: write at edge N -> CONV, 6-bit counter = 0.
REQ-016 Decimal render SHALL perform one shift-add-3 (double-dabble) step per edge on a 40-bit BCD register, over edges N+1..N+32.
REQ-017 Decimal render: RENDER follows edge N+32; outputs update at edge N+33; busy is high for exactly 33 cycles.
REQ-018 Decimal overflow: if BCD digits 9 or 8 are nonzero (VALUE > 99_999_999), every enabled digit SHALL show dash.
REQ-019 Decimal, no overflow: tub1..tub8 SHALL show BCD digits 7..0.
REQ-020 Suppression on: digits left of the most significant nonzero digit SHALL be blank; tub8 is never suppressed (value 0 shows FC on tub8).
REQ-021 A digit whose MASK bit is 0 SHALL output 00, regardless of mode, suppression or overflow.
REQ-022 Any accepted write while busy SHALL abort the current render and restart per REQ-013/REQ-015 using the updated registers.
REQ-023 Outputs SHALL hold their last rendered values while busy (no partial updates).

Reset
REQ-024 On rst_n low: state = IDLE, busy = 0, counter = 0, BCD register = 0, VALUE = 0, MODE = 0, MASK = FF, tub1..tub8 = 00.
REQ-025 Outputs SHALL stay blank until the first write after reset.
REQ-026 Reset asserted mid-conversion SHALL discard the conversion immediately.

Structure
REQ-027 The shared package SHALL hold: register address constants, MODE bit positions, FSM state encoding, the 16 digit codes, and the dash and blank codes.
REQ-028 SHALL instantiate one combinational sub-module, seg_lut (4-bit digit -> 8-bit code), once per digit, eight instances.

Verification
REQ-029 Reset; write MASK=FF; write VALUE=1234ABCD, MODE 0 -> one cycle later tub1..8 = 60,DA,F2,66,EE,3E,9C,7A; busy high 1 cycle.
REQ-030 Write MODE=1; write VALUE=12345678 -> busy high 33 cycles, then tub1..8 = 60,DA,F2,66,B6,BE,E0,FE.
REQ-031 MODE=1, VALUE=100000000 -> all tubs 02 after 33 cycles; same with MASK=0F -> tub1..4 = 00, tub5..8 = 02.
REQ-032 MODE=3: VALUE=42 -> tub1..6 = 00, tub7 = 66, tub8 = DA; VALUE=0 -> tub1..7 = 00, tub8 = FC.
REQ-033 MODE=1: write VALUE=11111111, then VALUE=87654321 on the 10th busy cycle -> tubs never show 1s; busy falls 33 cycles after the second write; tub1..8 = FE,E0,BE,B6,66,F2,DA,60.
REQ-034 Decimal conversion in progress, pulse rst_n low for 1 cycle -> busy 0 and all tubs 00 asynchronously; no update follows.

Source files
------------

// File: rtl/tub_encoder_pkg.sv
// Shared definitions for the seven-segment tube encoder: register map, MODE bits,
// FSM encoding, segment codes and the binary-to-BCD step helper.
package tub_encoder_pkg;

    localparam logic [1:0] ADDR_VALUE = 2'd0;
    localparam logic [1:0] ADDR_MODE  = 2'd1;
    localparam logic [1:0] ADDR_MASK  = 2'd2;
    localparam logic [1:0] ADDR_RSVD  = 2'd3;

    localparam int MODE_DEC_BIT = 0;
    localparam int MODE_LZS_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_RENDER = 2'd2
    } state_t;

    localparam logic [7:0] SEG_0 = 8'hFC;
    localparam logic [7:0] SEG_1 = 8'h60;
    localparam logic [7:0] SEG_2 = 8'hDA;
    localparam logic [7:0] SEG_3 = 8'hF2;
    localparam logic [7:0] SEG_4 = 8'h66;
    localparam logic [7:0] SEG_5 = 8'hB6;
    localparam logic [7:0] SEG_6 = 8'hBE;
    localparam logic [7:0] SEG_7 = 8'hE0;
    localparam logic [7:0] SEG_8 = 8'hFE;
    localparam logic [7:0] SEG_9 = 8'hF6;
    localparam logic [7:0] SEG_A = 8'hEE;
    localparam logic [7:0] SEG_B = 8'h3E;
    localparam logic [7:0] SEG_C = 8'h9C;
    localparam logic [7:0] SEG_D = 8'h7A;
    localparam logic [7:0] SEG_E = 8'h9E;
    localparam logic [7:0] SEG_F = 8'h8E;
    localparam logic [7:0] SEG_DASH  = 8'h02;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    // One double-dabble step: add 3 to every BCD digit >= 5, then shift {bcd, bin} left.
    function automatic logic [71:0] dabble_step(input logic [39:0] bcd, input logic [31:0] bin);
        logic [39:0] adj;
        adj = bcd;
        for (int d = 0; d < 10; d++) begin
            if (bcd[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
            end else begin
                adj[4*d +: 4] = bcd[4*d +: 4];
            end
        end
        return {adj[38:0], bin[31], bin[30:0], 1'b0};
    endfunction

endpackage

// File: rtl/tub_encoder_seg_lut.sv
// Combinational 4-bit digit to seven-segment code lookup.
module seg_lut
    import tub_encoder_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [7:0] o_code
);

    // Digit to segment pattern decode
    always_comb begin
        o_code = SEG_BLANK;
        case (i_digit)
            4'h0: o_code = SEG_0;
            4'h1: o_code = SEG_1;
            4'h2: o_code = SEG_2;
            4'h3: o_code = SEG_3;
            4'h4: o_code = SEG_4;
            4'h5: o_code = SEG_5;
            4'h6: o_code = SEG_6;
            4'h7: o_code = SEG_7;
            4'h8: o_code = SEG_8;
            4'h9: o_code = SEG_9;
            4'hA: o_code = SEG_A;
            4'hB: o_code = SEG_B;
            4'hC: o_code = SEG_C;
            4'hD: o_code = SEG_D;
            4'hE: o_code = SEG_E;
            4'hF: o_code = SEG_F;
            default: o_code = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/tub_encoder.sv
// MMIO-programmed eight-digit seven-segment encoder with hex or serial
// double-dabble decimal rendering, leading-zero suppression and per-digit mask.
module tub_encoder
    import tub_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic [7:0]  tub1,
    output logic [7:0]  tub2,
    output logic [7:0]  tub3,
    output logic [7:0]  tub4,
    output logic [7:0]  tub5,
    output logic [7:0]  tub6,
    output logic [7:0]  tub7,
    output logic [7:0]  tub8
);

    logic [31:0]      r_value;
    logic [1:0]       r_mode;
    logic [7:0]       r_mask;
    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_busy;
    logic [5:0]       r_cnt;
    logic [39:0]      r_bcd;
    logic [31:0]      r_bin;
    logic [7:0][7:0]  r_tubs;

    logic             w_wr_ok;
    logic [31:0]      w_value_nxt;
    logic [1:0]       w_mode_nxt;
    logic [71:0]      w_dabble;
    logic             w_overflow;
    logic [7:0][3:0]  w_nib;
    logic [7:0][7:0]  w_code;
    logic [7:0][7:0]  w_render;
    logic [7:0]       w_lead;

    // Values the registers take at this edge, so a restart sees the new settings.
    assign w_wr_ok     = wr_en && (addr != ADDR_RSVD);
    assign w_value_nxt = (wr_en && (addr == ADDR_VALUE)) ? wdata : r_value;
    assign w_mode_nxt  = (wr_en && (addr == ADDR_MODE)) ? wdata[1:0] : r_mode;
    assign w_dabble    = dabble_step(r_bcd, r_bin);

    // Programmable register file
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= 32'd0;
            r_mode  <= 2'd0;
            r_mask  <= 8'hFF;
        end else if (wr_en) begin
            case (addr)
                ADDR_VALUE: r_value <= wdata;
                ADDR_MODE:  r_mode  <= wdata[1:0];
                ADDR_MASK:  r_mask  <= wdata[7:0];
                default:    r_value <= r_value;
            endcase
        end
    end

    // FSM state register and registered busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    // FSM next state; any accepted write restarts the render
    always_comb begin
        w_state_nxt = r_state;
        if (w_wr_ok) begin
            if (w_mode_nxt[MODE_DEC_BIT]) begin
                w_state_nxt = ST_CONV;
            end else begin
                w_state_nxt = ST_RENDER;
            end
        end else begin
            case (r_state)
                ST_IDLE:   w_state_nxt = ST_IDLE;
                ST_CONV:   w_state_nxt = (r_cnt == 6'd31) ? ST_RENDER : ST_CONV;
                ST_RENDER: w_state_nxt = ST_IDLE;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Serial binary-to-BCD conversion datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 6'd0;
            r_bcd <= 40'd0;
            r_bin <= 32'd0;
        end else if (w_wr_ok) begin
            r_cnt <= 6'd0;
            r_bcd <= 40'd0;
            r_bin <= w_value_nxt;
        end else if (r_state == ST_CONV) begin
            r_cnt <= r_cnt + 6'd1;
            r_bcd <= w_dabble[71:32];
            r_bin <= w_dabble[31:0];
        end
    end

    assign w_overflow = r_mode[MODE_DEC_BIT] && (r_bcd[39:32] != 8'd0);

    for (genvar i = 0; i < 8; i++) begin : g_digit
        assign w_nib[i] = r_mode[MODE_DEC_BIT] ? r_bcd[4*(7-i) +: 4] : r_value[4*(7-i) +: 4];
        seg_lut u_seg_lut (
            .i_digit (w_nib[i]),
            .o_code  (w_code[i])
        );
    end

    // Final per-digit code: mask beats overflow beats suppression; index 0 is tub1
    always_comb begin
        w_lead   = 8'd0;
        w_render = '0;
        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin
                w_lead[i] = (w_nib[i] == 4'd0);
            end else begin
                w_lead[i] = w_lead[i-1] && (w_nib[i] == 4'd0);
            end
            if (!r_mask[7-i]) begin
                w_render[i] = SEG_BLANK;
            end else if (w_overflow) begin
                w_render[i] = SEG_DASH;
            end else if (r_mode[MODE_LZS_BIT] && w_lead[i] && (i != 7)) begin
                w_render[i] = SEG_BLANK;
            end else begin
                w_render[i] = w_code[i];
            end
        end
    end

    // Output registers load only on a completed render
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tubs <= '0;
        end else if ((r_state == ST_RENDER) && !w_wr_ok) begin
            r_tubs <= w_render;
        end
    end

    assign busy = r_busy;
    assign tub1 = r_tubs[0];
    assign tub2 = r_tubs[1];
    assign tub3 = r_tubs[2];
    assign tub4 = r_tubs[3];
    assign tub5 = r_tubs[4];
    assign tub6 = r_tubs[5];
    assign tub7 = r_tubs[6];
    assign tub8 = r_tubs[7];

endmodule

// File: tb/tb_tub_encoder.sv
// Directed self-checking bench for tub_encoder with hand-computed segment patterns.
module tb_tub_encoder;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  addr  = 2'd0;
    logic [31:0] wdata = 32'd0;
    logic        busy;
    logic [7:0]  tub1, tub2, tub3, tub4, tub5, tub6, tub7, tub8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tub_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (wr_en),
        .addr  (addr),
        .wdata (wdata),
        .busy  (busy),
        .tub1  (tub1),
        .tub2  (tub2),
        .tub3  (tub3),
        .tub4  (tub4),
        .tub5  (tub5),
        .tub6  (tub6),
        .tub7  (tub7),
        .tub8  (tub8)
    );

    function automatic logic [63:0] tubs();
        return {tub1, tub2, tub3, tub4, tub5, tub6, tub7, tub8};
    endfunction

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_en = 1'b1;
        addr  = a;
        wdata = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Counts busy cycles (bounded) and flags any tube change while busy.
    task automatic wait_idle(output int n, output bit changed);
        logic [63:0] held;
        held    = tubs();
        n       = 0;
        changed = 1'b0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
            if (busy && (tubs() !== held)) changed = 1'b1;
        end
    endtask

    task automatic render(input string tag, input logic [1:0] a, input logic [31:0] d,
                          input int exp_n, input logic [63:0] exp_tubs);
        int n;
        bit changed;
        wr(a, d);
        wait_idle(n, changed);
        check({tag, "_busy"}, 64'(n), 64'(exp_n));
        check({tag, "_hold"}, 64'(changed), 64'd0);
        check(tag, tubs(), exp_tubs);
    endtask

    initial begin
        int n;
        bit changed;
        logic [63:0] held;

        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_tubs", tubs(), 64'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_blank", tubs(), 64'd0);
        check("post_rst_idle", 64'(busy), 64'd0);

        render("mask_ff",   2'd2, 32'h0000_00FF, 1,  64'hFCFCFCFC_FCFCFCFC);
        render("rsvd_wr",   2'd3, 32'hFFFF_FFFF, 0,  64'hFCFCFCFC_FCFCFCFC);
        render("hex",       2'd0, 32'h1234_ABCD, 1,  64'h60DAF266_EE3E9C7A);
        render("dec_ovf",   2'd1, 32'd1,         33, 64'h02020202_02020202);
        render("dec",       2'd0, 32'd12345678,  33, 64'h60DAF266_B6BEE0FE);
        render("dec_1e8",   2'd0, 32'd100000000, 33, 64'h02020202_02020202);
        render("ovf_mask",  2'd2, 32'h0000_000F, 33, 64'h00000000_02020202);
        render("mask_back", 2'd2, 32'h0000_00FF, 33, 64'h02020202_02020202);
        render("mode3",     2'd1, 32'd3,         33, 64'h02020202_02020202);
        render("lzs_42",    2'd0, 32'd42,        33, 64'h00000000_000066DA);
        render("lzs_0",     2'd0, 32'd0,         33, 64'h00000000_000000FC);
        render("hex_lzs0",  2'd1, 32'd2,         1,  64'h00000000_000000FC);
        render("hex_lzs",   2'd0, 32'h0000_0A05, 1,  64'h00000000_00EEFCB6);
        render("dec_nolzs", 2'd1, 32'd1,         33, 64'hFCFCFCFC_DAB6BEB6);

        // Abort: second write lands on the 10th busy cycle of the first.
        wr(2'd0, 32'd11111111);
        held    = tubs();
        changed = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (tubs() !== held) changed = 1'b1;
        end
        check("abort_busy_pre", 64'(busy), 64'd1);
        wr(2'd0, 32'd87654321);
        if (tubs() !== held) changed = 1'b1;
        check("abort_hold_pre", 64'(changed), 64'd0);
        wait_idle(n, changed);
        check("abort_busy", 64'(n), 64'd33);
        check("abort_hold", 64'(changed), 64'd0);
        check("abort_tubs", tubs(), 64'hFEE0BEB6_66F2DA60);

        // Reset in the middle of a conversion.
        wr(2'd0, 32'd5);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_tubs", tubs(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("after_rst_busy", 64'(busy), 64'd0);
        check("after_rst_tubs", tubs(), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
